img_stream_gen: RTL
===================

IMG_STREAM_GEN -- requirements
Module: img_stream_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 Parameter H_ACTIVE, default 640: active pixels per line, range 2..4095.
REQ-003 Parameter H_BLANK, default 160: blank cycles per line, range 1..4095.
REQ-004 Parameter V_ACTIVE, default 480: active lines per frame, range 2..4095.
REQ-005 Parameters V_SYNC, V_BACK and V_FRONT, defaults 2, 33 and 10: vertical sync, back-porch and front-porch lines; each ranges 1..255.
REQ-006 Port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port start, input, 1 bit: request one frame; sampled only in IDLE.
REQ-009 Port cont, input, 1 bit: continuous mode; sampled on the last cycle of the front porch.
REQ-010 Port pattern_sel, input, 2 bits: selects 0 horizontal ramp, 1 vertical ramp, 2 checkerboard, 3 LFSR.
REQ-011 Port per_frame_vsync, output, 1 bit: vertical sync, active high.
REQ-012 Port per_frame_href, output, 1 bit: active-pixel qualifier.
REQ-013 Port per_img_y, output, DATA_WIDTH bits: pixel value.
REQ-014 Port busy, output, 1 bit: high in every state except IDLE.
REQ-015 Port frame_done, output, 1 bit: one-cycle pulse on the last cycle of each frame.

Function
REQ-016 The block SHALL implement the states IDLE, VSYNC, VBACK, ACTIVE and VFRONT; each non-IDLE state lasts an integer number of lines of H_TOTAL = H_ACTIVE + H_BLANK cycles.
REQ-017 The block SHALL leave IDLE when start=1 is sampled in cycle t, and SHALL enter VSYNC with per_frame_vsync=1 from cycle t+1.
REQ-018 The sequence SHALL be VSYNC (V_SYNC lines), then VBACK (V_BACK lines), then ACTIVE (V_ACTIVE lines), then VFRONT (V_FRONT lines).
REQ-019 per_frame_vsync SHALL be 1 exactly in VSYNC.
REQ-020 per_frame_href SHALL be 1 exactly during the first H_ACTIVE cycles of each ACTIVE line.
REQ-021 All outputs SHALL be registered; per_img_y SHALL be 0 whenever per_frame_href=0.
REQ-022 Counters: x (pixel in line) and y (active line index); y resets at frame start.
REQ-023 Pattern 0 SHALL output x mod 2^DATA_WIDTH.
REQ-024 Pattern 1 SHALL output y mod 2^DATA_WIDTH.
REQ-025 Pattern 2 SHALL output all ones when ((x>>3) XOR (y>>3)) bit 0 is 1, and 0 otherwise.
REQ-026 Pattern 3 SHALL output the low DATA_WIDTH bits of a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seeded to 16'hACE1 at frame start and advanced once per href cycle; the first pixel shows the seed.
REQ-027 pattern_sel SHALL be latched on entry to VSYNC; changes mid-frame SHALL have no effect until the next frame.
REQ-028 frame_done SHALL pulse on the final cycle of VFRONT.
REQ-029 In that cycle, cont=1 SHALL move the block to VSYNC on the next cycle with no gap; otherwise the block SHALL go to IDLE.
REQ-030 start SHALL be ignored while busy=1.
REQ-031 Counter widths SHALL be derived with $clog2 of the parameters; no counter SHALL wrap within a frame.

Reset
REQ-032 rst=1 SHALL force, asynchronously: state IDLE; all counters 0; LFSR 16'hACE1; latched pattern 0; every output 0.
REQ-033 Reset mid-frame SHALL abort the frame without a frame_done pulse.
REQ-034 After rst falls, the first frame SHALL start only on a fresh start.

Structure
REQ-035 The shared package img_stream_pkg SHALL hold the state enum, the pattern_sel codes, and the LFSR seed and tap constants.
REQ-036 The LFSR SHALL be the sub-module img_lfsr16 with ports clk, rst, load, advance and q[15:0]; everything else stays in img_stream_gen.

Verification (H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_SYNC=V_BACK=V_FRONT=1, DATA_WIDTH=8; start sampled in cycle 0)
REQ-037 Scenario: pattern 0 -> vsync=1 in cycles 1-6; href=1 in cycles 13-16, 19-22 and 25-28; data 0,1,2,3 on each line; frame_done in cycle 36; busy=0 from cycle 37.
REQ-038 Scenario: pattern 1 -> data is 0 x4 on line 0, 1 x4 on line 1, 2 x4 on line 2; per_img_y=0 in all blank cycles.
REQ-039 Scenario: cont=1 -> frame_done in cycles 36 and 72; vsync re-asserts in cycle 37; no IDLE cycle between frames.
REQ-040 Scenario: rst pulse in cycle 15 -> all outputs 0 immediately; no frame_done; start in cycle 20 gives vsync in cycles 21-26.
REQ-041 Scenario: start pulsed and pattern_sel switched to 2 in cycle 10 -> both ignored; frame completes with pattern 0 data; exactly one frame_done.
REQ-042 Scenario: pattern 3 over two frames -> first pixel 8'hE1; the 12-pixel sequence is identical in both frames and matches a reference LFSR model.

Source files
------------

// File: rtl/img_stream_pkg.sv
// img_stream_pkg: shared states, pattern codes and LFSR constants for the image stream generator
package img_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    localparam logic [1:0] PAT_HRAMP = 2'd0;
    localparam logic [1:0] PAT_VRAMP = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_LFSR  = 2'd3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/img_lfsr16.sv
// img_lfsr16: 16-bit Fibonacci LFSR with synchronous reload and advance enable
module img_lfsr16
    import img_stream_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= LFSR_SEED;
        else if (load)
            q <= LFSR_SEED;
        else if (advance)
            q <= {^(q & LFSR_TAPS), q[15:1]};
    end

endmodule

// File: rtl/img_stream_gen.sv
// img_stream_gen: frame timing generator emitting vsync/href and a selectable test pattern
module img_stream_gen
    import img_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int H_ACTIVE   = 640,
    parameter int H_BLANK    = 160,
    parameter int V_ACTIVE   = 480,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int V_FRONT    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cont,
    input  logic [1:0]            pattern_sel,
    output logic                  per_frame_vsync,
    output logic                  per_frame_href,
    output logic [DATA_WIDTH-1:0] per_img_y,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_MAX   = max2(max2(V_SYNC, V_BACK), max2(V_ACTIVE, V_FRONT));
    localparam int XW      = $clog2(H_TOTAL);
    localparam int LW      = $clog2(V_MAX);
    localparam int YW      = $clog2(V_ACTIVE + 1);

    state_t                state, nstate;
    logic [XW-1:0]         x, nx;
    logic [LW-1:0]         lc, nlc, lines_m1;
    logic [YW-1:0]         y, ny;
    logic [1:0]            pat, npat;
    logic [15:0]           lfsr_q;
    logic                  line_end, last_line, frame_end, new_frame, nhref, ck;
    logic [DATA_WIDTH-1:0] npix;

    img_lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (new_frame),
        .advance (nhref),
        .q       (lfsr_q)
    );

    always_comb begin
        lines_m1  = state == ST_VSYNC  ? LW'(V_SYNC - 1)   :
                    state == ST_VBACK  ? LW'(V_BACK - 1)   :
                    state == ST_ACTIVE ? LW'(V_ACTIVE - 1) : LW'(V_FRONT - 1);
        line_end  = x == XW'(H_TOTAL - 1);
        last_line = line_end && lc == lines_m1;
        frame_end = state == ST_VFRONT && last_line;
        new_frame = (state == ST_IDLE && start) || (frame_end && cont);
        nx        = (state == ST_IDLE || line_end) ? '0 : x + 1'b1;
        nlc       = !line_end ? lc : last_line ? '0 : lc + 1'b1;
        ny        = (state == ST_ACTIVE && line_end) ? y + 1'b1 : y;
        nstate    = !last_line          ? state     :
                    state == ST_VSYNC   ? ST_VBACK  :
                    state == ST_VBACK   ? ST_ACTIVE :
                    state == ST_ACTIVE  ? ST_VFRONT :
                    state == ST_VFRONT  ? ST_IDLE   : state;
        npat      = pat;
        if (new_frame) begin
            nstate = ST_VSYNC;
            nx     = '0;
            nlc    = '0;
            ny     = '0;
            npat   = pattern_sel;
        end
        nhref = nstate == ST_ACTIVE && nx < XW'(H_ACTIVE);
        ck    = 1'((16'(nx) >> 3) ^ (16'(ny) >> 3));
        npix  = !nhref               ? '0               :
                npat == PAT_HRAMP    ? DATA_WIDTH'(nx)  :
                npat == PAT_VRAMP    ? DATA_WIDTH'(ny)  :
                npat == PAT_CHECK    ? {DATA_WIDTH{ck}} : DATA_WIDTH'(lfsr_q);
    end

    // Outputs are registered from next-state values so they align with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            x               <= '0;
            lc              <= '0;
            y               <= '0;
            pat             <= PAT_HRAMP;
            per_frame_vsync <= 1'b0;
            per_frame_href  <= 1'b0;
            per_img_y       <= '0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            state           <= nstate;
            x               <= nx;
            lc              <= nlc;
            y               <= ny;
            pat             <= npat;
            per_frame_vsync <= nstate == ST_VSYNC;
            per_frame_href  <= nhref;
            per_img_y       <= npix;
            busy            <= nstate != ST_IDLE;
            frame_done      <= nstate == ST_VFRONT && nx == XW'(H_TOTAL - 1) && nlc == LW'(V_FRONT - 1);
        end
    end

endmodule
